shift_right_seq: RTL and testbench
==================================

// Module: shift_right_seq
// PURPOSE
//   Multicycle right shifter for the processor's srl/sra path. It shifts right
//   by one bit per clock, filling with zero (logical) or with A[WIDTH-1]
//   (arithmetic), until the requested amount is consumed.
//   It is the right-direction counterpart of the single-bit left-shift stage.
//   It sits beside the ALU and talks to the stall logic through a start/busy/done
//   handshake.
// PARAMETERS
//   WIDTH    32  data width in bits
//   SHW      5   shift-amount width; WIDTH must equal 2**SHW
// PORTS
//   clock    in   1      single clock; all state updates on posedge
//   reset    in   1      synchronous, active-high; returns block to IDLE
//   start    in   1      request; sampled only in IDLE
//   A        in   WIDTH  operand; captured on accepted start
//   shamt    in   SHW    shift amount; captured on accepted start
//   arith    in   1      1 = arithmetic (sign fill), 0 = logical (zero fill)
//   busy     out  1      high in SHIFT and DONE; start is ignored while high
//   done     out  1      one-cycle pulse; out is valid in that cycle
//   out      out  WIDTH  result; holds last result until next done or reset
// BEHAVIOUR
//   - Reset (sync, active-high): state=IDLE; busy=0, done=0, out=0;
//     internal shift reg and counter are cleared. Reset wins over start.
//   - IDLE, start=1 (accepted start): latch reg<=A, cnt<=shamt,
//     fill<=arith & A[WIDTH-1].
//     -> SHIFT if shamt!=0; -> DONE if shamt==0 (reg passes through unchanged).
//   - SHIFT: each cycle reg<={fill, reg[WIDTH-1:1]} and cnt<=cnt-1.
//     When cnt==1 this cycle (last shift), next state is DONE.
//   - DONE: done=1 and out=reg for exactly one cycle; busy stays 1; next state IDLE.
//     A start in this cycle is ignored.
//   - Latency: start accepted at edge t -> done high in cycle t+shamt+1.
//     shamt=0 gives 1 cycle; shamt=31 gives 32 cycles.
//   - out updates only on entry to DONE; it is stable at all other times.
//   - fill is frozen at capture. A, shamt and arith may change freely after
//     the accepted start without affecting the result.
//   - start while busy=1: no effect; no queuing.
//   - Back-to-back operation: the earliest next accepted start is the cycle
//     after done.
//   - Reset mid-operation: the operation is aborted, no done pulse, out=0.
//   - Illegal states decode to IDLE.
// TESTING
//   1 A=32'h80000000, shamt=4, arith=1
//     -> busy=1 for 5 cycles; done at t+5; out=32'hF8000000
//   2 Same with arith=0 -> out=32'h08000000 at t+5
//   3 A=32'h12345678, shamt=0 -> done at t+1; out=32'h12345678
//   4 A=32'h80000001, shamt=31: arith=1 -> out=32'hFFFFFFFF at t+32;
//     arith=0 -> out=32'h00000001
//   5 Start A=32'hF0, shamt=4; at t+2 pulse start with A=32'hFFFF, shamt=1
//     -> second request ignored; done at t+5; out=32'h0000000F
//   6 Start shamt=8; assert reset at t+3
//     -> next cycle busy=0, done=0, out=0; no done pulse;
//     a fresh start with A=32'h100, shamt=8 -> out=32'h1 at +9

Source files
------------

// File: rtl/shift_right_seq_if.sv
// Start/busy/done handshake and data bus between the stall logic and the
// multicycle right shifter.
interface shift_right_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [SHW-1:0]   shamt;
    logic             arith;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    modport master (
        output start, A, shamt, arith,
        input  busy, done, out
    );

    modport slave (
        input  start, A, shamt, arith,
        output busy, done, out
    );
endinterface

// File: rtl/shift_right_seq.sv
// Multicycle right shifter for srl/sra: shifts one bit per clock with zero
// or sign fill, then pulses done for one cycle with the result on out.
module shift_right_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic              clock,
    input logic              reset,
    shift_right_seq_if.slave bus
);

    if (WIDTH != 2 ** SHW) begin : g_bad_width
        $error("shift_right_seq: WIDTH must equal 2**SHW");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [WIDTH-1:0] out_q, out_next;
    logic [SHW-1:0]   cnt, cnt_next;
    logic             fill, fill_next;
    logic             busy, done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            fill  <= 1'b0;
            out_q <= '0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            cnt   <= cnt_next;
            fill  <= fill_next;
            out_q <= out_next;
        end
    end

    // out is loaded only on the transition into DONE, with the value the
    // shift register holds in that state, so it is stable everywhere else.
    always_comb begin
        state_next = IDLE;
        shreg_next = shreg;
        cnt_next   = cnt;
        fill_next  = fill;
        out_next   = out_q;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    shreg_next = bus.A;
                    cnt_next   = bus.shamt;
                    fill_next  = bus.arith & bus.A[WIDTH-1];
                    if (bus.shamt == '0) begin
                        state_next = DONE;
                        out_next   = bus.A;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                shreg_next = {fill, shreg[WIDTH-1:1]};
                cnt_next   = cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    state_next = DONE;
                    out_next   = {fill, shreg[WIDTH-1:1]};
                end else begin
                    state_next = SHIFT;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.out  = out_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Randomized and directed checks of shift_right_seq against an arithmetic
// reference (>> / >>>) including latency, busy, ignored starts and reset abort.
module tb_shift_right_seq;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    shift_right_seq_if #(.WIDTH(32), .SHW(5)) bus ();

    shift_right_seq #(.WIDTH(32), .SHW(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] refShift(input logic [31:0] a, input int sh, input bit ar);
        if (ar) return 32'($signed(a) >>> sh);
        return a >> sh;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one operation starting from IDLE; latency is counted in edges after
    // the accepting edge, so done must be seen exactly shamt edges later.
    task automatic applyStimulus(input logic [31:0] a, input logic [4:0] sh, input bit ar,
                                 input bit intrude, input bit pokeDone,
                                 input logic [31:0] expOut, input string tag);
        int lat;
        bit busyOk;
        bus.start = 1'b1;
        bus.A     = a;
        bus.shamt = sh;
        bus.arith = ar;
        tick();
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.shamt = 5'($urandom);
        bus.arith = ~ar;
        lat    = 0;
        busyOk = 1'b1;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy !== 1'b1) busyOk = 1'b0;
            tick();
            lat++;
            if (intrude && sh >= 3 && lat == 1) begin
                bus.start = 1'b1;
                bus.A     = 32'h0000FFFF;
                bus.shamt = 5'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        checkOutput({tag, "_latency"}, 32'(lat), 32'(sh));
        checkOutput({tag, "_busy_while_running"}, 32'(busyOk), 32'd1);
        checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
        checkOutput({tag, "_out"}, bus.out, expOut);
        if (pokeDone) begin
            bus.start = 1'b1;
            bus.A     = 32'hDEADBEEF;
            bus.shamt = 5'd0;
        end
        tick();
        bus.start = 1'b0;
        checkOutput({tag, "_idle_after_done"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_done_pulse_len"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_out_hold"}, bus.out, expOut);
    endtask

    initial begin
        logic [31:0] a;
        logic [4:0]  sh;
        bit          ar;
        bit          sawDone;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.shamt = '0;
        bus.arith = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_out", bus.out, 32'd0);
        bus.start = 1'b0;
        reset     = 1'b0;
        tick();

        applyStimulus(32'h80000000, 5'd4,  1'b1, 1'b0, 1'b0, 32'hF8000000, "sra4");
        applyStimulus(32'h80000000, 5'd4,  1'b0, 1'b0, 1'b0, 32'h08000000, "srl4");
        applyStimulus(32'h12345678, 5'd0,  1'b0, 1'b0, 1'b1, 32'h12345678, "sh0");
        applyStimulus(32'h80000001, 5'd31, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, "sra31");
        applyStimulus(32'h80000001, 5'd31, 1'b0, 1'b0, 1'b1, 32'h00000001, "srl31");
        applyStimulus(32'h000000F0, 5'd4,  1'b0, 1'b1, 1'b0, 32'h0000000F, "ignored_start");

        // Abort mid-operation: reset lands on the third edge after acceptance.
        bus.start = 1'b1;
        bus.A     = 32'hA5A5A5A5;
        bus.shamt = 5'd8;
        bus.arith = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_out", bus.out, 32'd0);
        sawDone = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) sawDone = 1'b1;
            tick();
        end
        checkOutput("abort_no_done", 32'(sawDone), 32'd0);
        applyStimulus(32'h00000100, 5'd8, 1'b0, 1'b0, 1'b0, 32'h00000001, "after_abort");

        for (int n = 0; n < 24; n++) begin
            a  = $urandom;
            sh = 5'($urandom_range(0, 31));
            ar = 1'($urandom_range(0, 1));
            applyStimulus(a, sh, ar, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          refShift(a, int'(sh), ar), $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
